// File: rtl/burst_trigger_controller.sv
// burst_trigger_controller
//
// Trigger-driven burst sequencer sitting between the trigger source and the
// NCO phase accumulator.
//
// With enable=1, an accepted trigger goes through four states:
//   1. Wait trig_delay clocks.
//   2. Pulse nco_clear.
//   3. Run the NCO for the captured number of waveform periods, counting a
//      period at each 1->0 transition of phase_msb.
//   4. Close the gate and refuse triggers for max(holdoff,1) clocks.
// With enable=0 the NCO free-runs and the DAC gate is open.
//
// Ports
//   clk, rst      : clock; asynchronous active-high reset
//   enable        : 1 = burst mode, 0 = free-run passthrough
//   trig          : single-cycle trigger pulse
//   burst_cycles  : periods per burst (0 behaves as 1), captured at trigger
//   trig_delay    : clocks from trigger to burst start, captured at trigger
//   holdoff       : clocks of trigger refusal after a burst, captured at trigger
//   phase_msb     : bit 31 of the NCO phase accumulator
//   nco_run       : accumulator advance enable
//   nco_clear     : one-cycle accumulator clear at burst start
//   out_gate      : 1 = DAC shows waveform, 0 = DAC held at mid-scale
//   busy          : high while a burst is pending, running or holding off
//   periods_done  : completed periods of the current/last burst
//   trig_missed   : one-cycle pulse after a refused trigger
//   dbg_state     : current FSM state (0 idle, 1 delay, 2 burst, 3 hold)
//
// Trigger handshake: trig is a one-cycle request with no ready signal. It is
// accepted only when the FSM is idle and enable=1. A trigger in any other
// enabled state is dropped, and trig_missed reports the drop on the
// following cycle.
//
// All outputs are registered. Each output is computed from the transition
// being taken, so an output reflects the new state in the same cycle that the
// state register does.

module burst_trigger_controller #(
  parameter int CNT_W = 16,
  parameter int DLY_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             trig,
  input  logic [CNT_W-1:0] burst_cycles,
  input  logic [DLY_W-1:0] trig_delay,
  input  logic [DLY_W-1:0] holdoff,
  input  logic             phase_msb,
  output logic             nco_run,
  output logic             nco_clear,
  output logic             out_gate,
  output logic             busy,
  output logic [CNT_W-1:0] periods_done,
  output logic             trig_missed,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [DLY_W-1:0] DLY_ZERO = '0;
  localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);

  logic [1:0]       state;
  logic [DLY_W-1:0] dly_cnt;   // shared by the DELAY and HOLD countdowns
  logic [DLY_W-1:0] hold_sh;
  logic [CNT_W-1:0] count_sh;
  logic             msb_d;
  logic             wrap;
  logic [CNT_W-1:0] pd_inc;

  assign wrap      = msb_d & ~phase_msb;
  assign pd_inc    = periods_done + CNT_ONE;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      dly_cnt      <= DLY_ZERO;
      hold_sh      <= DLY_ZERO;
      count_sh     <= CNT_ZERO;
      msb_d        <= 1'b0;
      nco_run      <= 1'b0;
      nco_clear    <= 1'b0;
      out_gate     <= 1'b0;
      busy         <= 1'b0;
      periods_done <= CNT_ZERO;
      trig_missed  <= 1'b0;
    end else begin
      nco_clear   <= 1'b0;
      trig_missed <= 1'b0;
      msb_d       <= phase_msb;
      if (!enable) begin
        // Passthrough: any burst in progress is abandoned; periods_done keeps
        // whatever count it had reached.
        state    <= S_IDLE;
        nco_run  <= 1'b1;
        out_gate <= 1'b1;
        busy     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            nco_run  <= 1'b0;
            out_gate <= 1'b0;
            busy     <= 1'b0;
            if (trig) begin
              count_sh <= (burst_cycles == CNT_ZERO) ? CNT_ONE : burst_cycles;
              hold_sh  <= holdoff;
              busy     <= 1'b1;
              if (trig_delay == DLY_ZERO) begin
                state        <= S_BURST;
                nco_clear    <= 1'b1;
                nco_run      <= 1'b1;
                out_gate     <= 1'b1;
                periods_done <= CNT_ZERO;
                // The accumulator sits at 0 during the clear, so stale history
                // must not produce a wrap on the first burst cycle.
                msb_d        <= 1'b0;
              end else begin
                state   <= S_DELAY;
                dly_cnt <= trig_delay;
              end
            end
          end
          S_DELAY: begin
            trig_missed <= trig;
            if (dly_cnt == DLY_ONE) begin
              state        <= S_BURST;
              nco_clear    <= 1'b1;
              nco_run      <= 1'b1;
              out_gate     <= 1'b1;
              periods_done <= CNT_ZERO;
              msb_d        <= 1'b0;
            end else begin
              dly_cnt <= dly_cnt - DLY_ONE;
            end
          end
          S_BURST: begin
            trig_missed <= trig;
            if (wrap) begin
              periods_done <= pd_inc;
              if (pd_inc == count_sh) begin
                state    <= S_HOLD;
                nco_run  <= 1'b0;
                out_gate <= 1'b0;
                dly_cnt  <= (hold_sh == DLY_ZERO) ? DLY_ONE : hold_sh;
              end
            end
          end
          default: begin  // S_HOLD
            trig_missed <= trig;
            if (dly_cnt == DLY_ONE) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              dly_cnt <= dly_cnt - DLY_ONE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/burst_trigger_controller.md
# burst_trigger_controller

Trigger-driven burst sequencer for the NCO/DAC datapath. It sits between the button/input layer and the phase accumulator. When burst mode is enabled, each accepted trigger waits a programmable delay, then clears and runs the NCO for exactly N waveform periods, gates the DAC to idle level, and enforces a hold-off before the next trigger. With burst mode disabled, it passes the NCO through free-running.

## Interface
- CNT_W, 16, width of burst period count and `periods_done`
- DLY_W, 24, width of trigger delay and hold-off counters (clock cycles)
- clk  in  1  100 MHz system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- enable  in  1  1 = burst mode; 0 = free-run passthrough
- trig  in  1  single-cycle trigger pulse (debounced button or external)
- burst_cycles  in  CNT_W  waveform periods per burst; 0 treated as 1
- trig_delay  in  DLY_W  clocks from trigger to burst start
- holdoff  in  DLY_W  clocks after burst end during which triggers are refused
- phase_msb  in  1  bit 31 of the NCO phase accumulator
- nco_run  out  1  phase accumulator advance enable
- nco_clear  out  1  one-cycle pulse forcing the accumulator to 0
- out_gate  out  1  1 = DAC shows waveform; 0 = top muxes DAC to 12'h800
- busy  out  1  high in DELAY, BURST, HOLD
- periods_done  out  CNT_W  completed periods of current/last burst
- trig_missed  out  1  one-cycle pulse: trigger refused

## Operation
- States: IDLE, DELAY, BURST, HOLD. All outputs are registered.
- Reset behaviour: all outputs are 0 and the state is IDLE.
- enable=0, any state:
  - The next edge forces IDLE.
  - Outputs: nco_run=1, out_gate=1, busy=0, nco_clear=0.
  - trig is ignored and does not set trig_missed.
  - periods_done holds.
- IDLE with enable=1: nco_run=0, out_gate=0.
- trig in IDLE:
  - Capture burst_cycles (0→1), trig_delay and holdoff into shadow registers.
  - If trig_delay==0, go to BURST; otherwise go to DELAY and load the counter with trig_delay.
  - Later input changes take effect only at the next accepted trigger.
- DELAY: decrement each cycle; enter BURST on the cycle the counter reaches 1.
- BURST entry cycle:
  - Outputs: nco_clear=1, nco_run=1, out_gate=1, periods_done=0.
  - The phase_msb history register is forced to 0.
- BURST:
  - A wrap is `phase_msb_d==1 && phase_msb==0`. Each wrap increments periods_done.
  - The wrap that makes periods_done equal the captured count moves the state to HOLD.
- HOLD: nco_run=0, out_gate=0. Stay for max(holdoff,1) cycles, then go to IDLE.
- trig while in DELAY, BURST or HOLD: ignored; trig_missed=1 on the next cycle.
- enable falling mid-DELAY/BURST/HOLD aborts to passthrough without completing the burst. Re-enabling returns to IDLE with the gate closed.
- Caller guarantees phase step < 2^31, so there is at most one wrap per cycle.

## Timing
- Trigger accepted at edge k:
  - nco_clear is high in cycle k+1+trig_delay.
  - busy rises at k+1.
- First accumulator advance occurs on the cycle after nco_clear (the accumulator is held at 0 during the clear).
- Wrap sampled at edge w:
  - periods_done updates at w+1.
  - On the final wrap, nco_run and out_gate drop at w+1. One DAC sample of the next period (phase near 0) is tolerated.
- HOLD exit: busy falls exactly holdoff cycles (minimum 1) after out_gate falls.
- A trigger arriving in the same cycle busy falls is refused.
- A trigger in the first IDLE cycle is accepted.
- enable toggle: outputs reflect the new mode one edge later.
- rst mid-burst clears immediately (asynchronous assertion). Release is sampled on clk; the first post-reset trigger behaves normally.

## Test plan
- Delay and burst length: enable=1, trig_delay=5, burst_cycles=3, holdoff=10; drive phase_msb square with a 100-clock period; pulse trig.
  - nco_clear high exactly 6 cycles after trig.
  - out_gate high for 3 periods; periods_done ends at 3.
  - busy falls 10 cycles after out_gate falls.
- Zero edge cases: trig_delay=0, burst_cycles=0.
  - nco_clear on the cycle after trig.
  - Burst ends after 1 wrap; periods_done=1.
- Refused triggers: trig during DELAY, BURST and HOLD.
  - Each produces a single trig_missed pulse.
  - Burst length unchanged; no restart.
- Shadow capture: change burst_cycles from 4 to 9 mid-burst.
  - Burst still stops at periods_done=4.
  - The next trigger yields a 9-period burst.
- Abort: drop enable during a burst at periods_done=2.
  - Next cycle: nco_run=1, out_gate=1, busy=0; periods_done stays 2.
- Reset: assert rst asynchronously mid-DELAY.
  - All outputs are 0 immediately.
  - After release, a trigger with trig_delay=2 gives nco_clear 3 cycles later.
